// File: rtl/cobertura_pkg.sv
// Shared types and default timing constants for the awning cover controller.
package cobertura_pkg;

  typedef enum logic [2:0] {
    ST_DEAD    = 3'd0,
    ST_OPEN    = 3'd1,
    ST_CLOSING = 3'd2,
    ST_CLOSED  = 3'd3,
    ST_OPENING = 3'd4,
    ST_FAULT   = 3'd5
  } state_e;

  localparam int unsigned FILT_CYCLES_DEF    = 16;
  localparam int unsigned DEAD_CYCLES_DEF    = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1000;
  localparam int unsigned CW_DEF             = 16;

endpackage

// File: rtl/cobertura_seq_filtro_sensor.sv
// Two-flop synchronizer plus persistence filter for the raw cover demand.
module filtro_sensor
  import cobertura_pkg::*;
#(
  parameter int unsigned FILT_CYCLES = FILT_CYCLES_DEF,
  parameter int unsigned CW          = CW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  localparam logic [CW-1:0] FILT_LAST = CW'(FILT_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          dem_q;
  logic          dem_d;

  // Counter only advances while the synced level disagrees with dem.
  always_comb begin
    cnt_d = '0;
    dem_d = dem_q;
    if (s2_q != dem_q) begin
      if (cnt_q >= FILT_LAST) begin
        dem_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      cnt_q <= '0;
      dem_q <= 1'b0;
    end else begin
      s1_q  <= d_i;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
      dem_q <= dem_d;
    end
  end

  assign q_o = dem_q;

endmodule

// File: rtl/cobertura_seq.sv
// Awning H-bridge sequencer: dead time, travel timeout
// and latched fault around the filtered light/rain demand.
module cobertura_seq
  import cobertura_pkg::*;
#(
  parameter int unsigned FILT_CYCLES    = FILT_CYCLES_DEF,
  parameter int unsigned DEAD_CYCLES    = DEAD_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CW             = CW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       L,
  input  logic       U,
  input  logic       Fe,
  input  logic       Fd,
  input  logic       clr_fault,
  output logic       A,
  output logic       B,
  output logic       fault,
  output logic [2:0] state
);

  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);

  logic          lu;
  logic          dem;
  logic          fe_s1_q;
  logic          fe_s_q;
  logic          fd_s1_q;
  logic          fd_s_q;
  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          a_q;
  logic          a_d;
  logic          b_q;
  logic          b_d;
  logic          fault_q;
  logic          fault_d;

  assign lu = L | U;

  filtro_sensor #(
    .FILT_CYCLES (FILT_CYCLES),
    .CW          (CW)
  ) u_filtro (
    .clk (clk),
    .rst (rst),
    .d_i (lu),
    .q_o (dem)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_DEAD: begin
        if (cnt_q >= DEAD_LAST) begin
          if (dem) begin
            state_d = fe_s_q ? ST_CLOSED : ST_CLOSING;
          end else begin
            state_d = fd_s_q ? ST_OPEN : ST_OPENING;
          end
        end
      end
      ST_CLOSING: begin
        if (cnt_q >= TO_LAST)  state_d = ST_FAULT;
        else if (fe_s_q)       state_d = ST_DEAD;
        else if (!dem)         state_d = ST_DEAD;
      end
      ST_OPENING: begin
        if (cnt_q >= TO_LAST)  state_d = ST_FAULT;
        else if (fd_s_q)       state_d = ST_DEAD;
        else if (dem)          state_d = ST_DEAD;
      end
      ST_OPEN: begin
        if (dem) state_d = ST_DEAD;
      end
      ST_CLOSED: begin
        if (!dem) state_d = ST_DEAD;
      end
      ST_FAULT: begin
        if (clr_fault && !(fe_s_q && fd_s_q)) begin
          state_d = ST_DEAD;
        end
      end
      default: state_d = ST_DEAD;
    endcase
    // Both limits closed at once can only mean broken wiring.
    if (fe_s_q && fd_s_q && state_q != ST_FAULT) begin
      state_d = ST_FAULT;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CW'(1);
    end
    a_d     = (state_d == ST_CLOSING);
    b_d     = (state_d == ST_OPENING);
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fe_s1_q <= 1'b0;
      fe_s_q  <= 1'b0;
      fd_s1_q <= 1'b0;
      fd_s_q  <= 1'b0;
      state_q <= ST_DEAD;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      fe_s1_q <= Fe;
      fe_s_q  <= fe_s1_q;
      fd_s1_q <= Fd;
      fd_s_q  <= fd_s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fault_q <= fault_d;
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign fault = fault_q;
  assign state = state_q;

endmodule

// File: tb/tb_cobertura_seq.sv
// Scoreboard bench: stimulus queues expected states per cycle,
// a negedge monitor pops and compares them.
module tb_cobertura_seq;
  import cobertura_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       l;
  logic       u;
  logic       fe;
  logic       fd;
  logic       clr;
  logic       a;
  logic       b;
  logic       flt;
  logic [2:0] st;

  typedef struct {
    int     cyc;
    state_e st;
    string  nm;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done    = 1'b0;

  cobertura_seq #(
    .FILT_CYCLES    (4),
    .DEAD_CYCLES    (3),
    .TIMEOUT_CYCLES (20),
    .CW             (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .L         (l),
    .U         (u),
    .Fe        (fe),
    .Fd        (fd),
    .clr_fault (clr),
    .A         (a),
    .B         (b),
    .fault     (flt),
    .state     (st)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a === 1'b1 && b === 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL excl: cyc=%0d A=1 B=1, required not both", cyc);
    end
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_tests++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: check for cyc %0d missed at cyc %0d",
                 e.nm, e.cyc, cyc);
      end else if (st !== 3'(e.st)
                   || a !== (e.st == ST_CLOSING)
                   || b !== (e.st == ST_OPENING)
                   || flt !== (e.st == ST_FAULT)) begin
        n_fail++;
        $display({"FAIL %s: cyc=%0d got state=%0d A=%b B=%b ",
                  "fault=%b, required state=%0d A=%b B=%b fault=%b"},
                 e.nm, cyc, st, a, b, flt, 3'(e.st),
                 e.st == ST_CLOSING, e.st == ST_OPENING,
                 e.st == ST_FAULT);
      end
    end
  end

  task automatic want(input int d, input state_e s, input string nm);
    exp_t x;
    int   i;
    x.cyc = cyc + d;
    x.st  = s;
    x.nm  = nm;
    i = q.size();
    while (i > 0 && q[i-1].cyc > x.cyc) i--;
    q.insert(i, x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    if (!done) begin
      n_fail++;
      $display("FAIL watchdog: time limit reached, required finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    rst = 1'b1; l = 1'b0; u = 1'b0;
    fe = 1'b0; fd = 1'b1; clr = 1'b0;
    tick(2);
    rst = 1'b0;
    // reset, dead time, then OPEN
    want(0, ST_DEAD, "rst_dead0");
    want(1, ST_DEAD, "rst_dead1");
    want(2, ST_DEAD, "rst_dead2");
    want(3, ST_OPEN, "rst_open");
    tick(5);
    // short rain pulse filtered away
    u = 1'b1;
    tick(3);
    u = 1'b0;
    want(5, ST_OPEN, "pulse_ign");
    tick(8);
    // held rain closes the cover
    u = 1'b1; fd = 1'b0;
    want(6, ST_OPEN, "dem_lat");
    want(7, ST_DEAD, "close_dead");
    want(9, ST_DEAD, "close_dead3");
    want(10, ST_CLOSING, "closing");
    tick(20);
    fe = 1'b1;
    want(2, ST_CLOSING, "fe_sync");
    want(3, ST_DEAD, "fe_reach");
    want(6, ST_CLOSED, "closed");
    tick(8);
    // dry again: open
    u = 1'b0; fe = 1'b0;
    want(6, ST_CLOSED, "closed_hold");
    want(7, ST_DEAD, "open_dead");
    want(10, ST_OPENING, "opening");
    tick(12);
    // reversal from OPENING
    u = 1'b1;
    want(6, ST_OPENING, "rev_o_hold");
    want(7, ST_DEAD, "rev_o_dead");
    want(10, ST_CLOSING, "rev_o_close");
    tick(12);
    // reversal from CLOSING
    u = 1'b0;
    want(6, ST_CLOSING, "rev_c_hold");
    want(7, ST_DEAD, "rev_c_dead");
    want(9, ST_DEAD, "rev_c_dead3");
    want(10, ST_OPENING, "rev_c_open");
    tick(12);
    fd = 1'b1;
    want(2, ST_OPENING, "fd_sync");
    want(3, ST_DEAD, "fd_reach");
    want(6, ST_OPEN, "open_again");
    tick(8);
    // travel timeout
    u = 1'b1; fd = 1'b0;
    want(7, ST_DEAD, "to_dead");
    want(10, ST_CLOSING, "to_start");
    want(29, ST_CLOSING, "to_last");
    want(30, ST_FAULT, "timeout");
    tick(32);
    clr = 1'b1;
    want(0, ST_FAULT, "fault_hold");
    tick(1);
    clr = 1'b0;
    want(0, ST_DEAD, "clr_dead");
    want(3, ST_CLOSING, "clr_close");
    tick(5);
    u = 1'b0; fd = 1'b1;
    want(6, ST_CLOSING, "back_hold");
    want(7, ST_DEAD, "back_dead");
    want(10, ST_OPEN, "back_open");
    tick(12);
    // dual-switch fault
    fe = 1'b1;
    want(2, ST_OPEN, "dual_sync");
    want(3, ST_FAULT, "dual_fault");
    tick(5);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    want(1, ST_FAULT, "dual_noclr");
    tick(2);
    fe = 1'b0;
    tick(3);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    want(0, ST_DEAD, "dual_clr");
    want(3, ST_OPEN, "dual_open");
    tick(5);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    want(0, ST_OPEN, "clr_ign0");
    want(3, ST_OPEN, "clr_ign3");
    tick(4);
    // reset mid-close
    u = 1'b1; fd = 1'b0;
    want(6, ST_OPEN, "r_pre_hold");
    want(10, ST_CLOSING, "r_pre_close");
    tick(12);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    want(0, ST_DEAD, "r_dead");
    want(3, ST_OPENING, "r_opening");
    want(6, ST_OPENING, "r_dem_lat");
    want(7, ST_DEAD, "r_rev_dead");
    want(10, ST_CLOSING, "r_closing");
    tick(12);
    for (int i = 0; i < 50 && q.size() > 0; i++) tick(1);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checks pending, required 0", q.size());
    end
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cobertura_seq.md
Name: cobertura_seq

Overview:
- Sequential controller for the awning motor H-bridge (A = close/counter-clockwise, B = open/clockwise).
- Replaces the purely combinational cover decision.
- Synchronizes and debounces the light (L) and rain (U) sensors and the end switches (Fe left = covered, Fd right = open).
- Enforces a dead time before every motor start, a travel timeout, and a latched fault state.

Parameters:
- FILT_CYCLES, 16, consecutive cycles a changed L|U level must persist before the cover demand changes (>=1).
- DEAD_CYCLES, 8, minimum motor-off cycles before any motor start or reversal (>=1).
- TIMEOUT_CYCLES, 1000, maximum motor-on cycles without reaching the target end switch (>=2).
- CW, 16, width of the shared cycle counter; must satisfy 2^CW > max(FILT_CYCLES, DEAD_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  single system clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- L  in  1  high light level (asynchronous, raw).
- U  in  1  high rain level (asynchronous, raw).
- Fe  in  1  left end switch, 1 = cover fully closed (asynchronous).
- Fd  in  1  right end switch, 1 = cover fully open (asynchronous).
- clr_fault  in  1  synchronous fault clear request.
- A  out  1  motor close drive, registered.
- B  out  1  motor open drive, registered.
- fault  out  1  latched fault indicator, registered.
- state  out  3  current FSM state encoding.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Input synchronization: L, U, Fe and Fd each pass through a 2-flop synchronizer; fe_s and fd_s are the synchronized switch values, with no filter.
- Cover demand (dem): dem <= sync(L|U) once the synced value has differed from dem for FILT_CYCLES consecutive cycles; the filter counter clears on any cycle where they are equal.
- Demand latency: a clean input step changes dem 2+FILT_CYCLES cycles after the input edge.
- State encoding: DEAD=0, OPEN=1, CLOSING=2, CLOSED=3, OPENING=4, FAULT=5.
- Output decode: A=1 iff state==CLOSING; B=1 iff state==OPENING. Outputs are registered with the state, never simultaneously 1. fault=1 iff state==FAULT.
- Reset values: state=DEAD, all counters=0, dem=0, A=B=fault=0.
- DEAD: the cycle counter counts from 0. After DEAD_CYCLES cycles in DEAD, the next state is chosen from dem and the switches:
  - dem=1, fe_s=1 -> CLOSED
  - dem=1, fe_s=0 -> CLOSING
  - dem=0, fd_s=1 -> OPEN
  - dem=0, fd_s=0 -> OPENING
- CLOSING:
  - fe_s=1 -> DEAD (then CLOSED).
  - dem falls to 0 -> DEAD (reversal path, guaranteeing the dead time).
  - Motor on for TIMEOUT_CYCLES cycles without fe_s -> FAULT.
- OPENING: mirror of CLOSING, using fd_s, dem rising to 1, and the same timeout.
- OPEN: dem=1 -> DEAD. fd_s dropping while idle does not move the motor.
- CLOSED: dem=0 -> DEAD. fe_s dropping while idle does not move the motor.
- Dual-switch fault: fe_s=fd_s=1 in any non-FAULT state -> FAULT on the next edge. This has priority over all other transitions.
- FAULT: A=B=0. Exits only when clr_fault=1 and !(fe_s&fd_s), going to DEAD. clr_fault is ignored in all other states.
- Cycle counter: one shared CW-bit counter, cleared on every state change, saturating (no wrap).
- Simultaneous events: switch-pair fault > timeout > reaching the limit > demand change.
- Reset mid-operation: any motor output drops on the edge where rst is sampled high, and the FSM restarts in DEAD.

Decomposition:
- Package cobertura_pkg: state enum/localparams (3-bit encoding above) and default parameter constants.
- One sub-module, filtro_sensor: 2-flop sync plus FILT_CYCLES persistence filter, parameterized. Instantiated once on the raw L|U.
- End-switch synchronizers stay inline in cobertura_seq.

Test Plan (FILT_CYCLES=4, DEAD_CYCLES=3, TIMEOUT_CYCLES=20):
1. Reset with L=U=0, Fe=0, Fd=1 -> state=DEAD for 3 cycles, then OPEN. A=B=fault=0 throughout.
2. From OPEN, U=1 for 3 cycles then 0 -> dem unchanged, state stays OPEN. U held at 1 -> dem=1 six cycles after the edge, DEAD for 3 cycles, then CLOSING with A=1. Raise Fe after 10 cycles -> A=0 three cycles later, DEAD, then CLOSED.
3. In CLOSING, drop L=U=0 and hold -> A=0 once dem falls, A=B=0 for exactly 3 cycles, then B=1 (OPENING). Fd=1 -> B=0, then OPEN.
4. Timeout: CLOSING with Fe held 0 -> A=1 for exactly 20 cycles, then state=FAULT, fault=1, A=B=0. Pulse clr_fault with Fe=Fd=0 -> DEAD, then CLOSING again.
5. In OPEN, set Fe=Fd=1 -> FAULT three cycles later. clr_fault ignored while both are high. Drop Fe, pulse clr_fault -> DEAD, then OPEN.
6. In CLOSING, assert rst for 1 cycle -> A=0 on that edge, state=DEAD, dem=0. With U still 1, CLOSING resumes after 2+4 filter cycles plus 3 dead-time cycles.
